io_input_cond: RTL
==================

// Module: io_input_cond
// PURPOSE
//  Conditions raw board inputs (switches, push-buttons) before the load-store unit
//  samples them. Synchronizes each input into i_clk and debounces the buttons.
//  Outputs drive the lsu i_io_sw / i_io_btn ports directly (ip_mem 0x7800 / 0x7810).
//  Also produces one-cycle press pulses for future interrupt/event logic.
// PARAMETERS
//  SYNC_STAGES  2        synchronizer depth per bit; legal values >= 2
//  DEB_CYCLES   500000   stable cycles required before a debounced bit changes (10 ms @ 50 MHz); >= 1
//  (local) CNT_W = $clog2(DEB_CYCLES+1)   width of each debounce counter
// PORTS
//  i_clk        in   1   system clock
//  i_rst        in   1   reset: synchronous, active-low
//  i_sw_raw     in   32  raw slide switches; asynchronous, active-high
//  i_btn_raw    in   4   raw push-buttons; asynchronous, active-low (pressed = 0)
//  o_io_sw      out  32  conditioned switches -> lsu i_io_sw
//  o_io_btn     out  4   debounced buttons, active-high (pressed = 1) -> lsu i_io_btn
//  o_btn_press  out  4   one-cycle pulse per button on its debounced 0->1 transition
// BEHAVIOUR
//  - Buttons are inverted before the first sync flop, so all internal state is active-high.
//  - Reset (i_rst=0 at a rising edge): all sync flops, debounce counters, o_io_sw,
//    o_io_btn and o_btn_press go to 0. Takes priority over every other update.
//  - Sync chain: SYNC_STAGES flops per bit, no logic between stages; s = last stage.
//  - Debounce, independently per button bit i (d = o_io_btn[i], c = counter[i]):
//      s == d                      : c <= 0
//      s != d, c <  DEB_CYCLES-1   : c <= c+1
//      s != d, c == DEB_CYCLES-1   : d <= s, c <= 0
//  - Latency: with raw held stable, o_io_btn[i] changes on rising edge SYNC_STAGES+DEB_CYCLES,
//    counting the first edge that samples the new raw value as edge 1.
//  - Glitch: any return of s to d before the terminal count clears c; output does not change.
//    Pulses shorter than DEB_CYCLES synced cycles never reach o_io_btn.
//  - o_btn_press[i] is registered: 1 for exactly one cycle, on the same edge o_io_btn[i] goes 0->1.
//    No pulse on release, and no pulse on the reset edge.
//  - Buttons are fully independent; simultaneous presses give simultaneous pulses.
//  - Counters saturate logically. c never exceeds DEB_CYCLES-1; no wrap-around is possible.
//  - Reset asserted mid-count: counter cleared, and the input must re-qualify from 0 after release.
//  - DEB_CYCLES = 1: output follows s one edge after s changes (counter is always 0).
// CONFIGURATION
//  SW_DEBOUNCE_EN defined:
//    each of the 32 switch bits gets its own counter and the same debounce rule as the buttons.
//    o_io_sw latency = SYNC_STAGES+DEB_CYCLES.
//  SW_DEBOUNCE_EN undefined (default):
//    switches are synchronized only; o_io_sw = s, latency = SYNC_STAGES edges.
//    No switch counters are instantiated.
//  Buttons are always debounced. o_btn_press exists in both builds.
// TESTING (bench uses SYNC_STAGES=2, DEB_CYCLES=4)
//  1 Reset: hold i_rst=0 for 3 edges with i_btn_raw=4'h0, i_sw_raw=32'hFFFF_FFFF
//    -> o_io_btn=0, o_io_sw=0, o_btn_press=0 throughout reset.
//  2 Clean press: i_btn_raw 4'hF->4'hE, held -> o_io_btn=4'h1 exactly at edge 6;
//    o_btn_press=4'h1 only at edge 6; release 4'hE->4'hF gives o_io_btn=0 at edge 6, no pulse.
//  3 Bounce: i_btn_raw[1] low for 3 cycles, high 1 cycle, then low and held
//    -> no change before the final low; o_io_btn[1]=1 at edge 6 of the final low; single pulse.
//  4 Simultaneous/independent: press btn0 and btn3 on the same edge, btn2 two edges later
//    -> o_io_btn=4'h9 with o_btn_press=4'h9 at edge 6; then 4'hD with o_btn_press=4'h4 two edges later.
//  5 Switches: i_sw_raw 0 -> 32'hA5A5_0003
//    -> o_io_sw updates at edge 2 (macro off) or at edge 6 (SW_DEBOUNCE_EN on);
//    a 2-cycle glitch is passed through (off) or filtered (on).
//  6 Reset mid-count: press btn0, assert i_rst=0 at edge 4, release reset at edge 5, keep pressed
//    -> o_io_btn stays 0 until 6 edges after reset release, then 1 with one pulse.

Source files
------------

// File: rtl/io_input_cond.sv
// Input conditioning for the board switches and push-buttons: synchronizes them into
// i_clk, debounces buttons (and switches when SW_DEBOUNCE_EN is defined), emits press pulses.
module io_input_cond #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned DEB_CYCLES  = 500000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [31:0] i_sw_raw,
  input  logic [3:0]  i_btn_raw,
  output logic [31:0] o_io_sw,
  output logic [3:0]  o_io_btn,
  output logic [3:0]  o_btn_press
);

  localparam int unsigned CNT_W = $clog2(DEB_CYCLES + 1);
  localparam logic [CNT_W-1:0] TERM = CNT_W'(DEB_CYCLES - 1);

  logic [SYNC_STAGES-1:0][31:0] sw_sync;
  logic [SYNC_STAGES-1:0][3:0]  btn_sync;
  logic [31:0]                  sw_s;
  logic [3:0]                   btn_s;
  logic [3:0][CNT_W-1:0]        btn_cnt;

  assign sw_s  = sw_sync[SYNC_STAGES-1];
  assign btn_s = btn_sync[SYNC_STAGES-1];

  // Buttons are inverted ahead of the first flop so everything downstream is active-high.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      sw_sync  <= '0;
      btn_sync <= '0;
    end else begin
      sw_sync[0]  <= i_sw_raw;
      btn_sync[0] <= ~i_btn_raw;
      for (int unsigned k = 1; k < SYNC_STAGES; k++) begin
        sw_sync[k]  <= sw_sync[k-1];
        btn_sync[k] <= btn_sync[k-1];
      end
    end
  end

  // Counter runs only while the synced level disagrees with the output; any agreement clears it.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      btn_cnt     <= '0;
      o_io_btn    <= '0;
      o_btn_press <= '0;
    end else begin
      o_btn_press <= '0;
      for (int unsigned i = 0; i < 4; i++) begin
        if (btn_s[i] == o_io_btn[i]) begin
          btn_cnt[i] <= '0;
        end else if (btn_cnt[i] != TERM) begin
          btn_cnt[i] <= btn_cnt[i] + CNT_W'(1);
        end else begin
          btn_cnt[i]     <= '0;
          o_io_btn[i]    <= btn_s[i];
          o_btn_press[i] <= btn_s[i];
        end
      end
    end
  end

`ifdef SW_DEBOUNCE_EN
  logic [31:0][CNT_W-1:0] sw_cnt;

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      sw_cnt  <= '0;
      o_io_sw <= '0;
    end else begin
      for (int unsigned i = 0; i < 32; i++) begin
        if (sw_s[i] == o_io_sw[i]) begin
          sw_cnt[i] <= '0;
        end else if (sw_cnt[i] != TERM) begin
          sw_cnt[i] <= sw_cnt[i] + CNT_W'(1);
        end else begin
          sw_cnt[i]  <= '0;
          o_io_sw[i] <= sw_s[i];
        end
      end
    end
  end
`else
  assign o_io_sw = sw_s;
`endif

endmodule
